// File: rtl/led_bar_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_bar_sequencer
// Brief    : Animated 10-segment bar-LED driver with an owned tick prescaler
//            and an IDLE/RUN/PAUSE controller driven by push-button pulses.
//            Optional macro LED_SEQ_ONESHOT_EN: stop in IDLE after one pass.
// Revision : 1.0  initial release
// ============================================================================
module led_bar_sequencer #(
    parameter int LED_W        = 10,
    parameter int PRESC_W      = 25,
    parameter int PRESCALE_MAX = 3000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             PAUSE,
    input  logic [1:0]       MODE,
    output logic [LED_W-1:0] LEDOUT,
    output logic             BUSY,
    output logic             WRAP
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [1:0] MODE_COUNT  = 2'b00;
    localparam logic [1:0] MODE_WALK   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(PRESCALE_MAX);
    localparam logic [LED_W-1:0]   LED_ONE   = LED_W'(1);
    localparam logic [LED_W-1:0]   LED_TWO   = LED_W'(2);
    localparam logic [LED_W-1:0]   LED_MSB   = {1'b1, {(LED_W-1){1'b0}}};

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] next_presc;
    logic [LED_W-1:0]   led;
    logic [LED_W-1:0]   next_led;
    logic               dir_down;
    logic               next_dir_down;
    logic [1:0]         mode_r;
    logic [1:0]         next_mode;
    logic               wrap_r;
    logic               next_wrap;

    logic               tick;
    logic [LED_W-1:0]   step_led;
    logic               step_dir_down;
    logic               wrap_event;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            presc    <= '0;
            led      <= '0;
            dir_down <= 1'b0;
            mode_r   <= 2'b00;
            wrap_r   <= 1'b0;
        end else begin
            state    <= next_state;
            presc    <= next_presc;
            led      <= next_led;
            dir_down <= next_dir_down;
            mode_r   <= next_mode;
            wrap_r   <= next_wrap;
        end
    end

    assign tick = (state == ST_RUN) && (presc == PRESC_TOP);

    // Candidate pattern step and whether that step closes a full pass
    always_comb begin
        step_led      = led;
        step_dir_down = dir_down;
        wrap_event    = 1'b0;
        case (mode_r)
            MODE_COUNT: begin
                step_led   = led + LED_ONE;
                wrap_event = (led == '1);
            end
            MODE_WALK: begin
                step_led   = {led[LED_W-2:0], led[LED_W-1]};
                wrap_event = (led == LED_MSB);
            end
            MODE_BOUNCE: begin
                if (!dir_down) begin
                    if (led[LED_W-1]) begin
                        step_dir_down = 1'b1;
                        step_led      = led >> 1;
                    end else begin
                        step_led      = led << 1;
                    end
                end else begin
                    if (led[0]) begin
                        step_dir_down = 1'b0;
                        step_led      = led << 1;
                    end else begin
                        step_led      = led >> 1;
                        wrap_event    = (led == LED_TWO);
                    end
                end
            end
            default: begin
                step_led   = ~led;
                wrap_event = (led == '1);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic; STOP beats START beats PAUSE
    // ------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        next_presc    = presc;
        next_led      = led;
        next_dir_down = dir_down;
        next_mode     = mode_r;
        next_wrap     = 1'b0;
        if (STOP) begin
            next_state = ST_IDLE;
            next_led   = '0;
            next_presc = '0;
        end else if (START) begin
            next_state    = ST_RUN;
            next_mode     = MODE;
            next_presc    = '0;
            next_dir_down = 1'b0;
            next_led      = (MODE == MODE_WALK || MODE == MODE_BOUNCE) ? LED_ONE : '0;
        end else begin
            case (state)
                ST_RUN: begin
                    next_state = PAUSE ? ST_PAUSE : ST_RUN;
                    if (tick) begin
                        next_presc    = '0;
                        next_led      = step_led;
                        next_dir_down = step_dir_down;
                        next_wrap     = wrap_event;
`ifdef LED_SEQ_ONESHOT_EN
                        if (wrap_event) begin
                            next_state = ST_IDLE;
                            next_led   = '0;
                        end
`endif
                    end else begin
                        next_presc = presc + PRESC_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (PAUSE) begin
                        next_state = ST_RUN;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        BUSY   = (state != ST_IDLE);
        LEDOUT = led;
        WRAP   = wrap_r;
    end

endmodule
`default_nettype wire

// File: tb/tb_led_bar_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_bar_sequencer
// Brief    : Scoreboard bench for led_bar_sequencer against a tick-count model.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_bar_sequencer;

    localparam int LED_W = 10;

    logic             clk;
    logic             RST;
    logic             START;
    logic             STOP;
    logic             PAUSE;
    logic [1:0]       MODE;
    logic [LED_W-1:0] LEDOUT;
    logic             BUSY;
    logic             WRAP;

    led_bar_sequencer #(
        .LED_W        (LED_W),
        .PRESC_W      (25),
        .PRESCALE_MAX (3)
    ) dut (
        .CLK    (clk),
        .RST    (RST),
        .START  (START),
        .STOP   (STOP),
        .PAUSE  (PAUSE),
        .MODE   (MODE),
        .LEDOUT (LEDOUT),
        .BUSY   (BUSY),
        .WRAP   (WRAP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LED_W-1:0] led;
        logic             busy;
        logic             wrap;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: pattern is a pure function of ticks since START
    int               m_state;   // 0 idle, 1 run, 2 pause
    int               m_rc;      // clocks spent in RUN since START
    int               m_k;       // ticks since START
    int               m_mode;
    logic [LED_W-1:0] m_led;
    logic             m_wrap;

    function automatic logic [LED_W-1:0] pat(input int md, input int k);
        logic [LED_W-1:0] one;
        int j;
        one = 1;
        case (md)
            0: return LED_W'(k % 1024);
            1: return one << (k % 10);
            2: begin
                j = k % 18;
                return (j <= 9) ? (one << j) : (one << (18 - j));
            end
            default: return (k % 2 == 1) ? 10'h3FF : 10'h000;
        endcase
    endfunction

    function automatic int period(input int md);
        case (md)
            0: return 1024;
            1: return 10;
            2: return 18;
            default: return 2;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic st, input logic sp,
                              input logic pa, input logic [1:0] md);
        bit   tick;
        exp_t e;
        tick   = (m_state == 1) && (m_rc % 4 == 3);
        m_wrap = 1'b0;
        if (r) begin
            m_state = 0; m_rc = 0; m_k = 0; m_mode = 0; m_led = '0;
        end else if (sp) begin
            m_state = 0; m_rc = 0; m_led = '0;
        end else if (st) begin
            m_mode = int'(md); m_rc = 0; m_k = 0; m_led = pat(int'(md), 0); m_state = 1;
        end else begin
            if (m_state == 1) begin
                m_rc++;
                if (tick) begin
                    m_k++;
                    m_led = pat(m_mode, m_k);
                    if (m_k % period(m_mode) == 0) begin
                        m_wrap = 1'b1;
`ifdef LED_SEQ_ONESHOT_EN
                        m_state = 0;
                        m_led   = '0;
`endif
                    end
                end
            end
            if (pa) begin
                if (m_state == 1)      m_state = 2;
                else if (m_state == 2) m_state = 1;
            end
        end
        e.led  = m_led;
        e.busy = (m_state != 0);
        e.wrap = m_wrap;
        e.cyc  = cycle;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic st, input logic sp,
                       input logic pa, input logic [1:0] md);
        RST = r; START = st; STOP = sp; PAUSE = pa; MODE = md;
        @(posedge clk);
        cycle++;
        model_step(r, st, sp, pa, md);
        #1;
        RST = 1'b0; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'($urandom));
    endtask

    // Monitor: compare every presented output against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (LEDOUT !== e.led) begin
                    errors++;
                    $display("FAIL ledout cycle %0d: got %h expected %h", e.cyc, LEDOUT, e.led);
                end
                checks++;
                if (BUSY !== e.busy) begin
                    errors++;
                    $display("FAIL busy cycle %0d: got %b expected %b", e.cyc, BUSY, e.busy);
                end
                checks++;
                if (WRAP !== e.wrap) begin
                    errors++;
                    $display("FAIL wrap cycle %0d: got %b expected %b", e.cyc, WRAP, e.wrap);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0; MODE = 2'b00;
        m_state = 0; m_rc = 0; m_k = 0; m_mode = 0; m_led = '0; m_wrap = 1'b0;
        #1;

        // Reset, then PAUSE while idle
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        idle_cycles(3);

        // Count through a full 1024-tick pass
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        idle_cycles(1030 * 4);

        // Bounce over two passes
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        idle_cycles(40 * 4);

        // Walk, pause mid-count for 20 clocks, resume
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
        idle_cycles(13);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        idle_cycles(20);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
        idle_cycles(30);

        // START and STOP together while running
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        idle_cycles(6);

        // Blink
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
        idle_cycles(20);

        // Reset mid-run
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        idle_cycles(4);

        // Randomized pulses
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 700) == 0,
                ($urandom % 60)  == 0,
                ($urandom % 200) == 0,
                ($urandom % 35)  == 0,
                2'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
